// File: rtl/amp3_sample_fifo.sv
// rtl/amp3_sample_fifo.sv - stereo sample FIFO feeding the AMP3 I2S transmitter
// Build option: AMP3_FIFO_REPEAT_EN replays the last pair when the FIFO runs dry.
module amp3_sample_fifo #(
   parameter int DEPTH_LOG2 = 3,
   parameter int WIDTH      = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_valid,
   output logic                  push_ready,
   input  logic [WIDTH-1:0]      push_R,
   input  logic [WIDTH-1:0]      push_L,
   output logic [WIDTH-1:0]      dataR,
   output logic [WIDTH-1:0]      dataL,
   output logic                  enable,
   input  logic                  idle,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  underrun,
   input  logic                  clear_underrun
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0]   CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      READY     = 2'd0,
      START     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_IDLE = 2'd3
   } state_t;

   state_t                  state, state_nxt;
   logic [2*WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
   logic                    do_push, do_pop, starve;

   assign push_ready = (count < FULL_COUNT);
   assign do_push    = push_valid & push_ready;

   always_comb begin
      state_nxt = state;
      do_pop    = 1'b0;
      starve    = 1'b0;
      case (state)
         READY: begin
            if (idle) begin
               if (count != '0) begin
                  do_pop    = 1'b1;
                  state_nxt = START;
               end else begin
                  starve = 1'b1;
`ifdef AMP3_FIFO_REPEAT_EN
                  state_nxt = START;
`else
                  state_nxt = READY;
`endif
               end
            end
         end
         START:     state_nxt = WAIT_BUSY;
         WAIT_BUSY: if (!idle) state_nxt = WAIT_IDLE;
         WAIT_IDLE: if (idle) state_nxt = READY;
         default:   state_nxt = READY;
      endcase
   end

   // Contents are not reset; clearing the pointers is enough to discard them.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= {push_R, push_L};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= READY;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         dataR    <= '0;
         dataL    <= '0;
         enable   <= 1'b0;
         underrun <= 1'b0;
      end else begin
         state  <= state_nxt;
         enable <= (state_nxt == START);
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop) begin
            rd_ptr         <= rd_ptr + PTR_ONE;
            {dataR, dataL} <= mem[rd_ptr];
         end
         if (do_push && !do_pop)
            count <= count + CNT_ONE;
         else if (!do_push && do_pop)
            count <= count - CNT_ONE;
         // A starvation event in the same cycle as a clear keeps the flag set.
         if (starve)
            underrun <= 1'b1;
         else if (clear_underrun)
            underrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_amp3_sample_fifo.sv
// tb/tb_amp3_sample_fifo.sv - scoreboard bench for amp3_sample_fifo
// Honours AMP3_FIFO_REPEAT_EN when the design is built with it.
module tb_amp3_sample_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        push_valid;
   logic [11:0] push_R, push_L;
   wire  [11:0] dataR, dataL;
   wire         push_ready, enable, underrun;
   wire  [3:0]  count;
   wire         idle;
   logic        clear_underrun;
   logic        manual, force_idle, model_idle;

   int          vectors = 0;
   int          miscompares = 0;
   logic [23:0] exp_q[$];
   logic [23:0] last_pair;
   logic [23:0] got, want;
   logic [23:0] hold_pair;
   logic        busy;
   int          busy_cnt;
   logic [11:0] seq;

   assign idle = manual ? force_idle : model_idle;

   always #5 clk = ~clk;

   amp3_sample_fifo #(.DEPTH_LOG2(3), .WIDTH(12)) dut (
      .clk(clk), .rst(rst), .push_valid(push_valid), .push_ready(push_ready),
      .push_R(push_R), .push_L(push_L), .dataR(dataR), .dataL(dataL),
      .enable(enable), .idle(idle), .count(count), .underrun(underrun),
      .clear_underrun(clear_underrun)
   );

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Monitor: every enable pulse must present the next pair the producer handed over.
   initial begin
      last_pair = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            last_pair = '0;
         end else if (enable) begin
            got = {dataR, dataL};
`ifdef AMP3_FIFO_REPEAT_EN
            if (exp_q.size() > 0 && got == exp_q[0]) begin
               want = exp_q.pop_front();
            end else if (got == last_pair) begin
               want = got;
            end else begin
               want = (exp_q.size() > 0) ? exp_q.pop_front() : last_pair;
            end
`else
            if (exp_q.size() > 0) begin
               want = exp_q.pop_front();
            end else begin
               want = ~got;
               $display("FAIL unexpected_enable: actual %0h required no frame", got);
            end
`endif
            chk("frame_data", int'(got), int'(want));
            last_pair = got;
         end
      end
   end

   // Behavioural transmitter: goes busy on enable, returns idle after a random frame time.
   initial begin
      model_idle = 1'b1;
      busy       = 1'b0;
      busy_cnt   = 0;
      hold_pair  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            model_idle = 1'b1;
            busy       = 1'b0;
         end else if (!manual) begin
            if (enable) begin
               chk("enable_while_busy", int'(busy), 0);
               busy       = 1'b1;
               busy_cnt   = $urandom_range(4, 1);
               hold_pair  = {dataR, dataL};
               model_idle = 1'b0;
            end else if (busy) begin
               chk("data_stable", int'({dataR, dataL}), int'(hold_pair));
               if (busy_cnt == 0) begin
                  model_idle = 1'b1;
                  busy       = 1'b0;
               end else begin
                  busy_cnt--;
               end
            end
         end
      end
   end

   task automatic offer(input logic [11:0] r, input logic [11:0] l);
      push_valid = 1'b1;
      push_R     = r;
      push_L     = l;
      if (push_ready) exp_q.push_back({r, l});
   endtask

   task automatic do_frame();
      logic seen = 1'b0;
      force_idle = 1'b1;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         seen = enable;
      end
      chk("frame_start", int'(seen), 1);
      force_idle = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic push_stream(input int n, input int pct, input bit counting);
      int acc = 0;
      int cyc = 0;
      while (acc < n && cyc < 5000) begin
         push_valid = ($urandom_range(99) < pct);
         push_R     = counting ? 12'(acc + 1) : seq;
         push_L     = counting ? 12'(acc + 1) : 12'($urandom);
         if (push_valid && push_ready) begin
            exp_q.push_back({push_R, push_L});
            acc++;
            if (!counting) seq++;
         end
         @(negedge clk);
         cyc++;
      end
      push_valid = 1'b0;
      chk("stream_accepted", acc, n);
   endtask

   initial begin
      int en_cnt;
      int cyc;
      rst = 1'b1; push_valid = 1'b0; push_R = '0; push_L = '0;
      clear_underrun = 1'b0; manual = 1'b1; force_idle = 1'b0; seq = 12'h001;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_count", int'(count), 0);
      chk("rst_push_ready", int'(push_ready), 1);
      chk("rst_enable", int'(enable), 0);
      chk("rst_underrun", int'(underrun), 0);
      chk("rst_dataR", int'(dataR), 0);
      chk("rst_dataL", int'(dataL), 0);

      // Single pair: accepted at edge N, loaded at N+1, enable for one cycle.
      offer(12'hA5A, 12'h468);
      @(negedge clk);
      push_valid = 1'b0;
      force_idle = 1'b1;
      chk("single_count_after_push", int'(count), 1);
      chk("single_enable_early", int'(enable), 0);
      @(negedge clk);
      chk("single_dataR", int'(dataR), 12'hA5A);
      chk("single_dataL", int'(dataL), 12'h468);
      chk("single_enable", int'(enable), 1);
      chk("single_count_after_pop", int'(count), 0);
      force_idle = 1'b0;
      @(negedge clk);
      chk("single_enable_one_cycle", int'(enable), 0);
      @(negedge clk);

      // Fill with the transmitter busy: eight accepted, ninth refused.
      for (int i = 0; i < 9; i++) begin
         if (i == 8) begin
            chk("fill_count", int'(count), 8);
            chk("fill_push_ready", int'(push_ready), 0);
         end
         offer(seq, 12'($urandom));
         if (push_ready) seq++;
         @(negedge clk);
      end
      push_valid = 1'b0;
      chk("fill_count_after_refused", int'(count), 8);
      for (int i = 0; i < 4; i++) do_frame();
      chk("half_drained_count", int'(count), 4);

      // Push and pop on the same edge at count=4.
      force_idle = 1'b1;
      @(negedge clk);
      offer(seq, 12'($urandom));
      seq++;
      @(negedge clk);
      push_valid = 1'b0;
      chk("simul_count", int'(count), 4);
      chk("simul_enable", int'(enable), 1);
      force_idle = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) do_frame();
      chk("drained_count", int'(count), 0);

      // Underrun: set wins over a simultaneous clear, clear works alone.
      force_idle = 1'b1;
      @(negedge clk);
      clear_underrun = 1'b1;
      @(negedge clk);
      clear_underrun = 1'b0;
      chk("underrun_set_wins", int'(underrun), 1);
      en_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (enable) en_cnt++;
         @(negedge clk);
      end
`ifdef AMP3_FIFO_REPEAT_EN
      chk("underrun_repeat_enable", int'(en_cnt > 0), 1);
`else
      chk("underrun_no_enable", en_cnt, 0);
`endif
      force_idle = 1'b0;
      clear_underrun = 1'b1;
      @(negedge clk);
      clear_underrun = 1'b0;
      chk("underrun_cleared", int'(underrun), 0);

      // Asynchronous reset mid-cycle with data buffered.
      for (int i = 0; i < 3; i++) begin
         offer(seq, 12'($urandom));
         seq++;
         @(negedge clk);
      end
      push_valid = 1'b0;
      chk("pre_reset_count", int'(count), 3);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_count", int'(count), 0);
      chk("async_rst_push_ready", int'(push_ready), 1);
      chk("async_rst_dataR", int'(dataR), 0);
      chk("async_rst_dataL", int'(dataL), 0);
      chk("async_rst_enable", int'(enable), 0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Randomised traffic against the behavioural transmitter.
      manual = 1'b0;
      seq = 12'h100;
      push_stream(20, 100, 1'b1);
      push_stream(150, 30, 1'b0);
      push_stream(60, 90, 1'b0);
      cyc = 0;
      while ((exp_q.size() != 0 || busy) && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      chk("drain_queue_empty", exp_q.size(), 0);
      repeat (3) @(negedge clk);
      chk("final_count", int'(count), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #900000;
      miscompares++;
      $display("FAIL watchdog: actual timeout required completion");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/amp3_sample_fifo.md
# amp3_sample_fifo

Stereo sample buffer sitting directly upstream of the Pmod AMP3 I2S transmitter (amp3_Lite). Accepts left/right 12-bit sample pairs from a producer via a valid/ready handshake, stores them in a small FIFO, and issues them to the transmitter one frame at a time using the transmitter's enable/idle handshake. Flags underruns when the transmitter is ready but no sample is available.

## Interface
- DEPTH_LOG2, 3: FIFO depth is 2^DEPTH_LOG2 sample pairs (default 8).
- WIDTH, 12: sample width per channel; matches transmitter data ports.

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; one clock, asynchronous and active-high.
- push_valid  in  1  producer has a sample pair on push_R/push_L.
- push_ready  out  1  FIFO can accept a pair; equals (count < 2^DEPTH_LOG2).
- push_R  in  WIDTH  right-channel sample to store.
- push_L  in  WIDTH  left-channel sample to store.
- dataR  out  WIDTH  right sample to transmitter, registered.
- dataL  out  WIDTH  left sample to transmitter, registered.
- enable  out  1  one-cycle start pulse to transmitter, registered.
- idle  in  1  transmitter idle/ready status.
- count  out  DEPTH_LOG2+1  number of stored pairs, 0..2^DEPTH_LOG2.
- underrun  out  1  sticky: set when a frame was due but FIFO empty.
- clear_underrun  in  1  synchronous clear of underrun.

## Operation
- Storage: 2^DEPTH_LOG2 entries of 2*WIDTH bits; write/read pointers DEPTH_LOG2 bits, wrap modulo depth; count tracks occupancy.
- Push: pair written at wr_ptr when push_valid & push_ready on a rising edge; wr_ptr++, count++.
- Pop FSM states:
  - READY: if idle=1 and count>0: load dataR/dataL from head, rd_ptr++, count--, go START. If idle=1 and count=0: set underrun, stay (see Configuration).
  - START: enable=1 for this cycle only; go WAIT_BUSY.
  - WAIT_BUSY: wait for idle=0; go WAIT_IDLE.
  - WAIT_IDLE: wait for idle=1; go READY.
- dataR/dataL held stable from load until next load; never change while a frame is in progress.
- Simultaneous push and pop in one cycle: both pointers advance, count unchanged. Push when full ignored (push_ready=0); full-to-not-full visible the cycle after a pop.
- underrun: set in READY on idle=1 & count=0; clear_underrun clears; set wins over clear in same cycle.

## Timing
- Reset values: dataR=0, dataL=0, enable=0, count=0, underrun=0, push_ready=1, state READY, pointers 0. Reset mid-frame discards FIFO contents and returns to READY; transmitter finishes its frame independently.
- Latency, empty FIFO with idle=1: push accepted edge N; count=1 after N; data loaded edge N+1; enable high cycle N+1..N+2 (one cycle); count back to 0 after N+1.
- Back-to-back frames: next load occurs the first edge idle=1 is seen in READY after WAIT_IDLE exits, i.e. 1 cycle after idle returns high.
- enable never asserted twice without an intervening idle 1->0->1 sequence.

## Configuration
- AMP3_FIFO_REPEAT_EN defined: on underrun in READY, FIFO empty and idle=1, re-issue the previously loaded pair (dataR/dataL unchanged) via START, so the transmitter plays the last sample continuously; underrun still set.
- Not defined: on underrun no enable is issued; FSM stays in READY until count>0; transmitter remains idle.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> all outputs at reset values immediately; push_ready=1, count=0.
- Single pair: push R=12'hA5A, L=12'h468 with idle=1 -> dataR=A5A, dataL=468 one edge later, enable high exactly one cycle after that, count returns 0.
- Fill: push 9 pairs with idle held 0 -> first 8 accepted, push_ready=0 after 8th, count=8, 9th not stored; release idle -> pairs emerge in order, one enable per idle 1->0->1 cycle.
- Wrap: push/pop 20 pairs (values 1..20) through depth-8 FIFO with model transmitter -> output sequence 1..20, no loss or duplicate.
- Underrun: empty FIFO, idle=1 -> underrun=1; clear_underrun -> 0. With AMP3_FIFO_REPEAT_EN, enable keeps pulsing with last pair; without, enable stays 0.
- Simultaneous push and pop at count=4 -> count stays 4, data order preserved.
